// File: rtl/read_d_pkg.sv
// read_d_pkg: shared types and constants for the read/D(i) fetch sequencer.
// Widths: AW = ROM address, DW = D(i), SW = symbol (00 A, 01 C, 10 G, 11 T).
package read_d_pkg;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam logic [AW-1:0] SENTINEL_ADDR = {AW{1'b1}};
  localparam logic [SW-1:0] SYM_A = 2'b00;
  localparam logic [SW-1:0] SYM_C = 2'b01;
  localparam logic [SW-1:0] SYM_G = 2'b10;
  localparam logic [SW-1:0] SYM_T = 2'b11;
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;
  typedef struct packed {
    logic [AW-1:0] idx;
    logic [SW-1:0] sym;
    logic [DW-1:0] d;
    logic          last;
  } entry_t;
  // The i = -1 sentinel never carries ROM data, whatever the ROM holds there.
  function automatic entry_t make_entry(input logic [AW-1:0] idx, input logic [SW-1:0] sym,
                                        input logic [DW-1:0] d);
    logic last;
    last = idx == SENTINEL_ADDR;
    return '{idx: idx, sym: last ? '0 : sym, d: last ? '0 : d, last: last};
  endfunction
endpackage

// File: rtl/read_d_fetch_seq_skid_buf.sv
// read_d_skid_buf: 2-entry valid/ready buffer between the ROM fetch stage and the search core.
// Ports: clk, rst (async, active high), flush (drops both entries),
//        in_valid/in_ready/in_data (push side), out_valid/out_ready/out_data (pop side).
module read_d_skid_buf import read_d_pkg::*; (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_data
);
  entry_t mem [2];
  logic rd, wr, push, pop;
  logic [1:0] count;
  // A full buffer still accepts when the head leaves in the same cycle, which keeps 1 entry/cycle.
  assign in_ready = count != 2'd2 || out_ready;
  assign out_valid = count != 2'd0;
  assign out_data = mem[rd];
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) mem[wr] <= in_data;
      wr <= wr ^ push;
      rd <= rd ^ pop;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/read_d_fetch_seq.sv
// read_d_fetch_seq: walks a read from i = len-1 down to the i = -1 sentinel, streaming (i, sym, D(i)).
// Ports: clk, rst (async, active high); start/abort pulses, len; busy/done status;
//        rom_ce/rom_addr out, rom_d_i/rom_read_i in; out_valid/out_ready handshake with
//        out_idx/out_sym/out_d/out_last payload.
// Build option READ_D_PREFETCH_EN: 2-entry skid buffer, fetch overlaps presentation (1 entry/cycle).
module read_d_fetch_seq import read_d_pkg::*; (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          rom_ce,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_d_i,
  input  logic [SW-1:0] rom_read_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [SW-1:0] out_sym,
  output logic [DW-1:0] out_d,
  output logic          out_last
);
  state_t state, state_n, present_nx;
  logic [AW-1:0] cnt;
  logic hs, fetch_adv, cnt_dec;
  entry_t fetched, head;
  assign rom_addr = cnt;
  assign fetched = make_entry(cnt, rom_read_i, rom_d_i);
  assign {out_idx, out_sym, out_d, out_last} = head;
  assign hs = out_valid && out_ready;
  assign busy = state == FETCH || state == PRESENT;
  assign done = state == DONE;
`ifdef READ_D_PREFETCH_EN
  logic in_ready;
  read_d_skid_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort && busy),
    .in_valid  (state == FETCH),
    .in_ready  (in_ready),
    .in_data   (fetched),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );
  // FETCH keeps issuing until the sentinel goes in; PRESENT only drains the buffer.
  assign rom_ce = state == FETCH && in_ready;
  assign fetch_adv = rom_ce && fetched.last;
  assign cnt_dec = rom_ce && !fetched.last;
  assign present_nx = PRESENT;
`else
  entry_t out_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else if (state == FETCH && !abort) out_q <= fetched;
  end
  assign head = out_q;
  assign out_valid = state == PRESENT;
  assign rom_ce = state == FETCH;
  assign fetch_adv = 1'b1;
  assign cnt_dec = state == PRESENT && hs && !out_q.last;
  assign present_nx = hs ? FETCH : PRESENT;
`endif
  always_comb begin
    state_n = IDLE;
    if (state == IDLE) state_n = start ? FETCH : IDLE;
    else if (state == FETCH) state_n = abort ? DONE : fetch_adv ? PRESENT : FETCH;
    else if (state == PRESENT) state_n = (abort || (hs && out_last)) ? DONE : present_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) cnt <= len - AW'(1);
      else if (cnt_dec) cnt <= cnt - AW'(1);
    end
  end
endmodule

// File: tb/tb_read_d_fetch_seq.sv
// tb_read_d_fetch_seq: table-driven walks plus abort, reset and throughput sequences, checked by a scoreboard.
module tb_read_d_fetch_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, out_ready;
  logic [7:0] len = 8'd0;
  logic busy, done, rom_ce, out_valid, out_last;
  logic [7:0] rom_addr, rom_d_i, out_idx, out_d;
  logic [1:0] rom_read_i, out_sym;
  typedef struct packed {logic [7:0] idx; logic [1:0] sym; logic [7:0] d; logic last;} exp_t;
  typedef struct {logic [7:0] len; int rm; int n;} vec_t;
  exp_t exp_q[$];
  exp_t held, got, e;
  logic held_v = 1'b0;
  logic [1:0] rom_sym [256];
  logic [7:0] rom_d [256];
  int n_chk = 0, n_fail = 0, n_hs = 0, n_done = 0, cyc = 0, rmode = 0;
  int first_v = -1, first_hs = -1, last_hs = -1;
  vec_t vecs [6];

  read_d_fetch_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len), .busy(busy), .done(done),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_d_i(rom_d_i), .rom_read_i(rom_read_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_sym(out_sym),
    .out_d(out_d), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign rom_read_i = rom_sym[rom_addr];
  assign rom_d_i = rom_d[rom_addr];

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rmode == 1 ? !out_ready : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) held_v = 1'b0;
    else begin
      got = {out_idx, out_sym, out_d, out_last};
      if (held_v) begin
        n_chk++;
        if (!out_valid || got !== held) begin
          n_fail++;
          $display("FAIL hold_stable: got valid=%b %h, required valid=1 %h", out_valid, got, held);
        end
      end
      held_v = out_valid && !out_ready;
      held = got;
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) begin
        n_hs++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL entry_extra: got %h, required no entry", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL entry: got idx=%h sym=%b d=%h last=%b, required idx=%h sym=%b d=%h last=%b",
                     out_idx, out_sym, out_d, out_last, e.idx, e.sym, e.d, e.last);
          end
        end
      end
      if (done) n_done++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] l);
    for (int i = int'(l) - 1; i >= 0; i--) exp_q.push_back({8'(i), 2'(i), 8'(2 * i + 1), 1'b0});
    exp_q.push_back({8'hFF, 2'b00, 8'h00, 1'b1});
  endtask

  task automatic pulse_start(input logic [7:0] l, output int sc);
    @(posedge clk);
    #1 len = l;
    start = 1'b1;
    sc = cyc;
    first_v = -1;
    first_hs = -1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic walk(input logic [7:0] l, input int rm, input int n, input string nm);
    int hs0, d0, sc;
    rmode = rm;
    push_exp(l);
    hs0 = n_hs;
    d0 = n_done;
    pulse_start(l, sc);
    for (int k = 0; k < 300 && n_done == d0; k++) begin
      @(posedge clk);
      #2;
    end
    chk({nm, "_done_seen"}, 64'(n_done != d0), 64'd1);
    repeat (2) @(posedge clk);
    #2;
    chk({nm, "_entries"}, 64'(n_hs - hs0), 64'(n));
    chk({nm, "_done_once"}, 64'(n_done - d0), 64'd1);
    chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_latency"}, 64'(first_v - sc), 64'd2);
    chk({nm, "_busy_low"}, 64'(busy), 64'd0);
    exp_q.delete();
    rmode = 0;
  endtask

  initial begin
    int hs0, d0, sc;
    logic found;
    vecs[0] = '{8'd3, 0, 4};
    vecs[1] = '{8'd0, 0, 1};
    vecs[2] = '{8'd4, 1, 5};
    vecs[3] = '{8'd1, 1, 2};
    vecs[4] = '{8'd7, 0, 8};
    vecs[5] = '{8'd2, 1, 3};
    for (int i = 0; i < 256; i++) begin
      rom_sym[i] = 2'(i);
      rom_d[i] = 8'(2 * i + 1);
    end
    #12;
    chk("reset_outputs", 64'({busy, done, rom_ce, rom_addr, out_valid, out_idx, out_sym, out_d, out_last}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int v = 0; v < 6; v++) walk(vecs[v].len, vecs[v].rm, vecs[v].n, $sformatf("vec%0d", v));

    walk(8'd3, 0, 4, "tput");
`ifdef READ_D_PREFETCH_EN
    chk("tput_span", 64'(last_hs - first_hs), 64'd3);
`else
    chk("tput_span", 64'(last_hs - first_hs), 64'd6);
`endif

    rmode = 0;
    push_exp(8'd5);
    hs0 = n_hs;
    d0 = n_done;
    pulse_start(8'd5, sc);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      found = out_valid && out_idx == 8'd3;
    end
    chk("abort_reach_2nd", 64'(found), 64'd1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_valid_low", 64'(out_valid), 64'd0);
    chk("abort_done", 64'(done), 64'd1);
    chk("abort_busy_low", 64'(busy), 64'd0);
    @(posedge clk);
    #2;
    chk("abort_rom_ce", 64'(rom_ce), 64'd0);
    chk("abort_entries", 64'(n_hs - hs0), 64'd2);
    chk("abort_done_once", 64'(n_done - d0), 64'd1);
    exp_q.delete();
    walk(8'd5, 0, 6, "restart");

    push_exp(8'd6);
    pulse_start(8'd6, sc);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midwalk_reset", 64'({busy, done, rom_ce, rom_addr, out_valid, out_idx, out_sym, out_d, out_last}), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    walk(8'd3, 0, 4, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
